// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared types for the SDRAM port arbiter and its per-port trackers.
//   ARB_ADDR_W  : SDRAM byte address width (default for the top-level ADDR_W)
//   arb_state_e : command FSM states
//   port_e      : client port identifiers
//   port_req_t  : request a tracker presents to the arbiter
package sdram_arb_pkg;

  localparam int ARB_ADDR_W = 25;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_PPU = 1'b1
  } port_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  we;
    logic [7:0]            wdata;
  } port_req_t;

endpackage

// File: rtl/sdram_port_tracker.sv
// sdram_port_tracker
// Turns one mapper port's free-running address / write-level signals into
// discrete read and write requests, and holds the port's read data.
// Ports:
//   sysclk, reset      clock, synchronous active-low reset
//   i_bus              port address
//   i_wr, i_wdata      write level (rising edge = one write) and write data
//   i_grant            arbiter granted this port this cycle (IDLE->ISSUE)
//   i_grant_done       this port's write command was accepted
//   i_rd_done          this port's read data returned (i_rd_data valid)
//   o_req              request presented to the arbiter
//   o_rd_pending       read wanted
//   o_wr_pending       buffered write waiting for issue
//   o_rdata            held read data
//   o_overrun          sticky: buffered write overwritten before issue
module sdram_port_tracker
  import sdram_arb_pkg::*;
(
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic [ARB_ADDR_W-1:0] i_bus,
  input  logic                  i_wr,
  input  logic [7:0]            i_wdata,
  input  logic                  i_grant,
  input  logic                  i_grant_done,
  input  logic                  i_rd_done,
  input  logic [7:0]            i_rd_data,
  output port_req_t             o_req,
  output logic                  o_rd_pending,
  output logic                  o_wr_pending,
  output logic [7:0]            o_rdata,
  output logic                  o_overrun
);

  logic [ARB_ADDR_W-1:0] r_last_addr;
  logic                  r_valid;
  logic                  r_wr_prev;
  logic                  r_armed;
  logic [ARB_ADDR_W-1:0] r_wbuf_addr;
  logic [7:0]            r_wbuf_data;
  logic                  r_wbuf_full;
  logic                  r_reissue;
  logic                  r_wr_inflight;
  logic                  r_rd_inflight;
  logic                  r_rd_pending;
  logic [ARB_ADDR_W-1:0] r_rd_addr;
  logic [ARB_ADDR_W-1:0] r_iss_addr;
  logic [7:0]            r_iss_data;
  logic [7:0]            r_rdata;
  logic                  r_overrun;

  logic      w_wr_edge;
  logic      w_wr_pending;
  logic      w_wr_busy;
  logic      w_buf_live;
  logic      w_rd_busy;
  logic      w_rd_pend_nxt;
  port_req_t w_req;

  // Request decode: edge detect, pending flags and the presented request.
  always_comb begin
    // r_armed suppresses an edge in the first post-reset cycle, so a level
    // held high across reset release is not mistaken for a new write.
    w_wr_edge    = i_wr && !r_wr_prev && r_armed;
    w_wr_pending = r_wbuf_full && !r_wr_inflight;
    w_req.we     = w_wr_pending;
    w_req.wdata  = r_wbuf_data;
    if (w_wr_pending) begin
      w_req.addr = r_wbuf_addr;
    end else begin
      w_req.addr = r_rd_addr;
    end
    // A write is "busy" from the grant cycle until its ack; a capture in that
    // window refills the buffer after the issued data was already latched.
    w_wr_busy  = r_wr_inflight || (i_grant && w_req.we);
    // Buffer holds data that has not been handed to the arbiter yet.
    w_buf_live = r_wbuf_full && (!w_wr_busy || r_reissue);
    // Looking one cycle ahead keeps the registered pending flag from
    // re-asserting on the grant cycle or on the stale state at read return.
    w_rd_busy     = r_rd_inflight || (i_grant && !w_req.we);
    w_rd_pend_nxt = !i_wr && (!r_valid || (i_bus != r_last_addr)) && !w_rd_busy;
  end

  // Tracker state: edge history, write buffer, in-flight flags, read data.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_last_addr   <= {ARB_ADDR_W{1'b0}};
      r_valid       <= 1'b0;
      r_wr_prev     <= 1'b0;
      r_armed       <= 1'b0;
      r_wbuf_addr   <= {ARB_ADDR_W{1'b0}};
      r_wbuf_data   <= 8'h00;
      r_wbuf_full   <= 1'b0;
      r_reissue     <= 1'b0;
      r_wr_inflight <= 1'b0;
      r_rd_inflight <= 1'b0;
      r_rd_pending  <= 1'b0;
      r_rd_addr     <= {ARB_ADDR_W{1'b0}};
      r_iss_addr    <= {ARB_ADDR_W{1'b0}};
      r_iss_data    <= 8'h00;
      r_rdata       <= 8'h00;
      r_overrun     <= 1'b0;
    end else begin
      r_wr_prev    <= i_wr;
      r_armed      <= 1'b1;
      r_rd_pending <= w_rd_pend_nxt;
      r_rd_addr    <= i_bus;

      if (i_grant) begin
        r_iss_addr <= w_req.addr;
        r_iss_data <= w_req.wdata;
      end

      if (i_grant && !w_req.we) begin
        r_rd_inflight <= 1'b1;
      end else if (i_rd_done) begin
        r_rd_inflight <= 1'b0;
      end

      if (i_grant && w_req.we) begin
        r_wr_inflight <= 1'b1;
      end else if (i_grant_done) begin
        r_wr_inflight <= 1'b0;
      end

      if (w_wr_edge) begin
        r_wbuf_addr <= i_bus;
        r_wbuf_data <= i_wdata;
      end

      // New capture wins over the ack clearing the buffer.
      if (w_wr_edge) begin
        r_wbuf_full <= 1'b1;
      end else if (i_grant_done) begin
        r_wbuf_full <= r_reissue;
      end

      if (i_grant_done) begin
        r_reissue <= 1'b0;
      end else if (w_wr_edge && w_wr_busy) begin
        r_reissue <= 1'b1;
      end

      if (w_wr_edge && w_buf_live) begin
        r_overrun <= 1'b1;
      end

      if (i_rd_done) begin
        r_rdata     <= i_rd_data;
        r_last_addr <= r_iss_addr;
        r_valid     <= 1'b1;
      end else if (i_grant_done && r_valid && (r_iss_addr == r_last_addr)) begin
        // Write-through keeps the cached byte coherent without a re-read.
        r_rdata <= r_iss_data;
      end
    end
  end

  assign o_req        = w_req;
  assign o_rd_pending = r_rd_pending;
  assign o_wr_pending = w_wr_pending;
  assign o_rdata      = r_rdata;
  assign o_overrun    = r_overrun;

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Serves the CPU and PPU mapper ports onto a single-request SDRAM controller
// command interface, round-robin between ports, write before read per port.
// Ports:
//   sysclk, reset                    clock, synchronous active-low reset
//   cpu_bus/cpu_wr/cpu_wdata         CPU port address, write level, data
//   cpu_rdata                        CPU port held read data
//   ppu_bus/ppu_wr/ppu_wdata         PPU port address, write level, data
//   ppu_rdata                        PPU port held read data
//   mem_req/mem_we/mem_addr/mem_wdata  command to the SDRAM controller
//   mem_ack                          command accepted this cycle
//   mem_rvalid/mem_rdata             one-cycle read data return
//   wr_overrun                       sticky {ppu,cpu} write overrun flags
// ADDR_W must stay equal to ARB_ADDR_W; the request struct uses the latter.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_bus,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  input  logic [ADDR_W-1:0] ppu_bus,
  input  logic              ppu_wr,
  input  logic [7:0]        ppu_wdata,
  output logic [7:0]        ppu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        wr_overrun
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  port_e      r_sel;
  port_e      r_last;
  port_e      w_pick;
  port_req_t  r_cmd;
  port_req_t  w_cmd_nxt;
  logic       r_mem_req;
  logic       w_mem_req_nxt;
  logic       w_start;
  logic       w_wr_done;
  logic       w_rd_done;

  port_req_t  w_cpu_req;
  port_req_t  w_ppu_req;
  logic       w_cpu_rd_pend;
  logic       w_cpu_wr_pend;
  logic       w_ppu_rd_pend;
  logic       w_ppu_wr_pend;
  logic       w_cpu_work;
  logic       w_ppu_work;
  logic       w_cpu_ov;
  logic       w_ppu_ov;

  assign w_cpu_work = w_cpu_rd_pend || w_cpu_wr_pend;
  assign w_ppu_work = w_ppu_rd_pend || w_ppu_wr_pend;

  sdram_port_tracker u_cpu (
    .sysclk       (sysclk),
    .reset        (reset),
    .i_bus        (cpu_bus),
    .i_wr         (cpu_wr),
    .i_wdata      (cpu_wdata),
    .i_grant      (w_start && (w_pick == PORT_CPU)),
    .i_grant_done (w_wr_done && (r_sel == PORT_CPU)),
    .i_rd_done    (w_rd_done && (r_sel == PORT_CPU)),
    .i_rd_data    (mem_rdata),
    .o_req        (w_cpu_req),
    .o_rd_pending (w_cpu_rd_pend),
    .o_wr_pending (w_cpu_wr_pend),
    .o_rdata      (cpu_rdata),
    .o_overrun    (w_cpu_ov)
  );

  sdram_port_tracker u_ppu (
    .sysclk       (sysclk),
    .reset        (reset),
    .i_bus        (ppu_bus),
    .i_wr         (ppu_wr),
    .i_wdata      (ppu_wdata),
    .i_grant      (w_start && (w_pick == PORT_PPU)),
    .i_grant_done (w_wr_done && (r_sel == PORT_PPU)),
    .i_rd_done    (w_rd_done && (r_sel == PORT_PPU)),
    .i_rd_data    (mem_rdata),
    .o_req        (w_ppu_req),
    .o_rd_pending (w_ppu_rd_pend),
    .o_wr_pending (w_ppu_wr_pend),
    .o_rdata      (ppu_rdata),
    .o_overrun    (w_ppu_ov)
  );

  // Next-state, grant selection and next command fields.
  always_comb begin
    w_state_nxt   = r_state;
    w_pick        = r_sel;
    w_cmd_nxt     = r_cmd;
    w_mem_req_nxt = r_mem_req;
    w_start       = 1'b0;
    w_wr_done     = 1'b0;
    w_rd_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cpu_work || w_ppu_work) begin
          w_start = 1'b1;
          // PPU wins when alone, or on a tie when CPU was granted last.
          if (w_ppu_work && (!w_cpu_work || (r_last == PORT_CPU))) begin
            w_pick    = PORT_PPU;
            w_cmd_nxt = w_ppu_req;
          end else begin
            w_pick    = PORT_CPU;
            w_cmd_nxt = w_cpu_req;
          end
          w_mem_req_nxt = 1'b1;
          w_state_nxt   = ISSUE;
        end else begin
          w_mem_req_nxt = 1'b0;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          if (r_cmd.we) begin
            w_wr_done   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT_RD;
          end
        end else begin
          w_mem_req_nxt = 1'b1;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          w_rd_done   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_RD;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command registers, granted port and round-robin pointer.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_mem_req <= 1'b0;
      r_cmd     <= '{addr: {ARB_ADDR_W{1'b0}}, we: 1'b0, wdata: 8'h00};
      r_sel     <= PORT_CPU;
      r_last    <= PORT_CPU;
    end else begin
      r_mem_req <= w_mem_req_nxt;
      r_cmd     <= w_cmd_nxt;
      if (w_start) begin
        r_sel  <= w_pick;
        r_last <= w_pick;
      end
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_cmd.we;
  assign mem_addr   = r_cmd.addr;
  assign mem_wdata  = r_cmd.wdata;
  assign wr_overrun = {w_ppu_ov, w_cpu_ov};

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: the bench plays the SDRAM controller
// (ack / rvalid) and compares every observation against hand-derived values.
module tb_sdram_port_arbiter;

  localparam int AW = 25;

  logic          sysclk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] cpu_bus = '0;
  logic          cpu_wr = 1'b0;
  logic [7:0]    cpu_wdata = 8'h00;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] ppu_bus = '0;
  logic          ppu_wr = 1'b0;
  logic [7:0]    ppu_wdata = 8'h00;
  logic [7:0]    ppu_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [7:0]    mem_rdata = 8'h00;
  logic [1:0]    wr_overrun;

  int n_checks = 0;
  int n_fail = 0;
  int cnt;

  sdram_port_arbiter #(.ADDR_W(AW)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .cpu_bus    (cpu_bus),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .ppu_bus    (ppu_bus),
    .ppu_wr     (ppu_wr),
    .ppu_wdata  (ppu_wdata),
    .ppu_rdata  (ppu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wr_overrun (wr_overrun)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the next command.
  task automatic wait_req(input string tag);
    int cyc = 0;
    while (mem_req !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_req"}, 32'(mem_req), 32'd1);
  endtask

  task automatic ack();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic rvalid_after(input int lat, input logic [7:0] d);
    for (int i = 1; i < lat; i++) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
  endtask

  task automatic serve_read(input string tag, input logic [AW-1:0] a, input logic [7:0] d);
    wait_req(tag);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'(a));
    check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
    ack();
    rvalid_after(2, d);
  endtask

  task automatic quiet(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (mem_req === 1'b1) c++;
    end
  endtask

  logic [AW-1:0] rr_exp [3];

  initial begin
    rr_exp[0] = 25'h000600;
    rr_exp[1] = 25'h000501;
    rr_exp[2] = 25'h000602;

    // Reset state
    cpu_bus = 25'h000123;
    ppu_bus = 25'h000200;
    repeat (3) tick();
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("rst_ppu_rdata", 32'(ppu_rdata), 32'd0);
    check_eq("rst_overrun", 32'(wr_overrun), 32'd0);

    // First reads after release: tie -> PPU first, then CPU at R+2
    reset = 1'b1;
    tick();
    check_eq("rel_n1_req", 32'(mem_req), 32'd0);
    tick();
    check_eq("rel_n2_req", 32'(mem_req), 32'd1);
    check_eq("first_ppu_addr", 32'(mem_addr), 32'h000200);
    check_eq("first_ppu_we", 32'(mem_we), 32'd0);
    ack();
    check_eq("ack_drop_req", 32'(mem_req), 32'd0);
    rvalid_after(2, 8'h77);
    check_eq("ppu_rdata_77", 32'(ppu_rdata), 32'h77);
    check_eq("r1_req_low", 32'(mem_req), 32'd0);
    tick();
    check_eq("r2_req_high", 32'(mem_req), 32'd1);
    check_eq("cpu_rd_addr", 32'(mem_addr), 32'h000123);
    ack();
    rvalid_after(2, 8'h5A);
    check_eq("cpu_rdata_5a", 32'(cpu_rdata), 32'h5A);
    check_eq("ppu_rdata_hold", 32'(ppu_rdata), 32'h77);
    quiet(10, cnt);
    check_eq("stable_no_cmd", 32'(cnt), 32'd0);

    // Both ports change together, then continuous alternation
    cpu_bus = 25'h000300;
    ppu_bus = 25'h000400;
    serve_read("tie_ppu", 25'h000400, 8'h44);
    serve_read("tie_cpu", 25'h000300, 8'h33);
    check_eq("tie_ppu_rdata", 32'(ppu_rdata), 32'h44);
    check_eq("tie_cpu_rdata", 32'(cpu_rdata), 32'h33);
    cpu_bus = 25'h000500;
    ppu_bus = 25'h000600;
    for (int i = 0; i < 3; i++) begin
      wait_req("alt");
      check_eq("alt_addr", 32'(mem_addr), 32'(rr_exp[i]));
      ack();
      cpu_bus = 25'h000501 + 25'(i);
      ppu_bus = 25'h000601 + 25'(i);
      rvalid_after(2, 8'(i));
    end
    serve_read("drain_cpu", 25'h000503, 8'h01);
    serve_read("drain_ppu", 25'h000603, 8'h02);

    // Write-through on a cached address
    cpu_bus = 25'h100010;
    serve_read("wt_prime", 25'h100010, 8'h99);
    check_eq("wt_prime_rdata", 32'(cpu_rdata), 32'h99);
    cpu_wdata = 8'h3C;
    cpu_wr = 1'b1;
    wait_req("wt");
    check_eq("wt_we", 32'(mem_we), 32'd1);
    check_eq("wt_addr", 32'(mem_addr), 32'h100010);
    check_eq("wt_wdata", 32'(mem_wdata), 32'h3C);
    ack();
    cpu_wr = 1'b0;
    tick();
    check_eq("wt_rdata", 32'(cpu_rdata), 32'h3C);
    quiet(8, cnt);
    check_eq("wt_no_read", 32'(cnt), 32'd0);

    // Overrun: two CPU writes while a PPU read is stalled
    ppu_bus = 25'h000700;
    wait_req("ovr_ppu");
    check_eq("ovr_ppu_addr", 32'(mem_addr), 32'h000700);
    cpu_wdata = 8'h11;
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    tick();
    cpu_wdata = 8'h22;
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    tick();
    check_eq("ovr_flag", 32'(wr_overrun), 32'h1);
    check_eq("ovr_req_held", 32'(mem_req), 32'd1);
    check_eq("ovr_addr_held", 32'(mem_addr), 32'h000700);
    ack();
    rvalid_after(2, 8'h70);
    wait_req("ovr_wr");
    check_eq("ovr_wr_we", 32'(mem_we), 32'd1);
    check_eq("ovr_wr_wdata", 32'(mem_wdata), 32'h22);
    check_eq("ovr_wr_addr", 32'(mem_addr), 32'h100010);
    ack();
    tick();
    check_eq("ovr_wt_rdata", 32'(cpu_rdata), 32'h22);
    quiet(8, cnt);
    check_eq("ovr_single_write", 32'(cnt), 32'd0);
    check_eq("ovr_sticky", 32'(wr_overrun), 32'h1);

    // Address moves during WAIT_RD
    cpu_bus = 25'h000800;
    wait_req("mv1");
    check_eq("mv1_addr", 32'(mem_addr), 32'h000800);
    ack();
    cpu_bus = 25'h000900;
    rvalid_after(2, 8'hA1);
    check_eq("mv1_rdata", 32'(cpu_rdata), 32'hA1);
    serve_read("mv2", 25'h000900, 8'hB2);
    check_eq("mv2_rdata", 32'(cpu_rdata), 32'hB2);

    // Reset during ISSUE, stray rvalid after release
    cpu_bus = 25'h000A00;
    wait_req("rst_iss");
    check_eq("rst_iss_addr", 32'(mem_addr), 32'h000A00);
    reset = 1'b0;
    tick();
    check_eq("rst_iss_req", 32'(mem_req), 32'd0);
    check_eq("rst_iss_cpu", 32'(cpu_rdata), 32'd0);
    check_eq("rst_iss_ppu", 32'(ppu_rdata), 32'd0);
    check_eq("rst_iss_ovr", 32'(wr_overrun), 32'd0);
    tick();
    reset = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 8'hEE;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata = 8'h00;
    check_eq("stray1_cpu", 32'(cpu_rdata), 32'd0);

    // Pointer back at CPU: PPU wins the tie; then reset during WAIT_RD
    wait_req("ptr");
    check_eq("ptr_ppu_addr", 32'(mem_addr), 32'h000700);
    ack();
    cpu_wdata = 8'h55;
    cpu_wr = 1'b1;
    reset = 1'b0;
    tick();
    check_eq("rst_wait_req", 32'(mem_req), 32'd0);
    check_eq("rst_wait_ppu", 32'(ppu_rdata), 32'd0);
    tick();
    reset = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 8'hEE;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata = 8'h00;
    check_eq("stray2_ppu", 32'(ppu_rdata), 32'd0);
    check_eq("stray2_cpu", 32'(cpu_rdata), 32'd0);

    // wr held high through release: only the PPU read, no write
    serve_read("post_rst", 25'h000700, 8'h66);
    check_eq("post_rst_rdata", 32'(ppu_rdata), 32'h66);
    quiet(10, cnt);
    check_eq("held_wr_no_write", 32'(cnt), 32'd0);
    check_eq("post_rst_ovr", 32'(wr_overrun), 32'd0);
    cpu_wr = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
